// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// New values are staged in a pending register and take effect only at frame boundaries.
module seven_segment_scanner #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic                 en_q;
    logic                 pend_q, pend_d;
    logic [4*DIGITS-1:0]  pend_val_q, pend_val_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [4*DIGITS-1:0]  shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]    anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 frame_done_q, frame_done_d;
    logic                 boundary;
    logic [DIGITS-1:0]    lz_mask;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // A digit is a leading zero when it and everything above it is zero and it carries no dp.
    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        lz_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_zero    = hi_zero & (shadow_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = hi_zero & ~shadow_dp_q[i];
        end
    end

    always_comb begin
        boundary     = en & (~en_q | ((cnt_q == CNT_MAX) & (digit_q == DIG_MAX)));
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        state_d      = state_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        anode_d      = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;

        if (!en) begin
            cnt_d   = '0;
            digit_d = '0;
            state_d = ST_BLANK;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (BLANK_CYCLES == 0 || cnt_d == BLANK_LIM) begin
                state_d = ST_SHOW;
            end else if (cnt_d == '0) begin
                state_d = ST_BLANK;
            end
        end

        // The shadow takes the pending content as it was before this cycle's load.
        if (boundary && pend_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
        end
        if (load) begin
            pend_d     = 1'b1;
            pend_val_d = value;
            pend_dp_d  = dp_in;
        end else if (boundary) begin
            pend_d = 1'b0;
        end

        if (en && state_q == ST_SHOW && !(lz_blank && lz_mask[digit_q])) begin
            anode_d[digit_q] = 1'b0;
            seg_d            = hex_to_seg(shadow_val_q[4*digit_q +: 4]);
            dp_d             = ~shadow_dp_q[digit_q];
        end
        frame_done_d = en && state_q == ST_SHOW && cnt_q == CNT_MAX && digit_q == DIG_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= '0;
            en_q         <= 1'b0;
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            anode_q      <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            en_q         <= en;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a position-in-frame reference model plus directed and random scenarios.
module tb_seven_segment_scanner;
    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, load = 1'b0, lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  anode, anode2;
    logic [6:0]  seg, seg2;
    logic        dp, dp2, fd, fd2;
    int          checks = 0;
    int          passed = 0;

    seven_segment_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .anode(anode), .seg(seg), .dp(dp), .frame_done(fd));

    seven_segment_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .anode(anode2), .seg(seg2), .dp(dp2), .frame_done(fd2));

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40; 4'h1: seg_of = 7'h79; 4'h2: seg_of = 7'h24; 4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19; 4'h5: seg_of = 7'h12; 4'h6: seg_of = 7'h02; 4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00; 4'h9: seg_of = 7'h10; 4'hA: seg_of = 7'h08; 4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46; 4'hD: seg_of = 7'h21; 4'hE: seg_of = 7'h06; default: seg_of = 7'h0E;
        endcase
    endfunction

    // Reference model: m_t is the number of enabled cycles since the scan (re)started.
    int          m_t;
    logic        m_fresh, m_en_prev, m_pend;
    logic [15:0] m_shadow, m_pval;
    logic [3:0]  m_sdp, m_pdp;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    int          m_offs, m_slot;
    logic        m_show, m_supp, m_bound;

    always_comb begin
        m_offs  = m_t % CLK_DIV;
        m_slot  = (m_t / CLK_DIV) % DIGITS;
        m_show  = en && !m_fresh && (m_offs >= BLANK_CYCLES);
        m_supp  = lz_blank && (m_slot > 0) && ((m_shadow >> (4 * m_slot)) == 16'h0) && !m_sdp[m_slot];
        m_bound = en && (!m_en_prev || (m_offs == CLK_DIV - 1 && m_slot == DIGITS - 1));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0; m_fresh <= 1'b1; m_en_prev <= 1'b0; m_pend <= 1'b0;
            m_shadow <= '0; m_pval <= '0; m_sdp <= '0; m_pdp <= '0;
            exp_anode <= 4'hF; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
        end else begin
            exp_anode <= 4'hF; exp_seg <= 7'h7F; exp_dp <= 1'b1;
            if (m_show && !m_supp) begin
                exp_anode <= ~(4'b0001 << m_slot);
                exp_seg   <= seg_of(m_shadow[4*m_slot +: 4]);
                exp_dp    <= ~m_sdp[m_slot];
            end
            exp_fd <= m_show && m_offs == CLK_DIV - 1 && m_slot == DIGITS - 1;
            if (m_bound && m_pend) begin
                m_shadow <= m_pval; m_sdp <= m_pdp;
            end
            if (load) begin
                m_pend <= 1'b1; m_pval <= value; m_pdp <= dp_in;
            end else if (m_bound) begin
                m_pend <= 1'b0;
            end
            m_en_prev <= en;
            if (en) begin
                m_t <= m_t + 1; m_fresh <= 1'b0;
            end else begin
                m_t <= 0; m_fresh <= 1'b1;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0; value = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({anode, seg, dp, fd} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_state anode=%b seg=%b dp=%b fd=%b expected 1111 1111111 1 0", anode, seg, dp, fd);
        else passed++;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL idle_blank cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
        end
    endtask

    task automatic test_basic_scan();
        int pulses = 0;
        value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL scan_1234 cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (fd) pulses++;
            if (k == 3 || k == 11 || k == 19 || k == 27) begin
                logic [3:0] ea;
                logic [6:0] es;
                case (k)
                    3:       begin ea = 4'b1110; es = 7'b0011001; end
                    11:      begin ea = 4'b1101; es = 7'b0110000; end
                    19:      begin ea = 4'b1011; es = 7'b0100100; end
                    default: begin ea = 4'b0111; es = 7'b1111001; end
                endcase
                checks++;
                if (anode !== ea || seg !== es)
                    $display("FAIL scan_digit cyc=%0d anode=%b seg=%b expected %b %b", k, anode, seg, ea, es);
                else passed++;
            end
        end
        checks++;
        if (pulses != 3) $display("FAIL frame_done_count got %0d expected 3", pulses);
        else passed++;
    endtask

    task automatic test_midframe_load();
        bit found = 0, seen2 = 0, seen0 = 0, seen3 = 0, seenc = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (anode == 4'b1101) found = 1;
        end
        checks++;
        if (!found) $display("FAIL wait_digit1 anode=%b expected 1101 within 40 cycles", anode);
        else passed++;
        value = 16'hABCD; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL midframe cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (anode == 4'b1011 && !seen2) begin
                seen2 = 1; checks++;
                if (seg !== 7'b0100100) $display("FAIL old_frame_digit2 seg=%b expected 0100100", seg);
                else passed++;
            end
            if (anode == 4'b1110 && !seen0) begin
                seen0 = 1; checks++;
                if (seg !== 7'b0100001) $display("FAIL new_frame_digit0 seg=%b expected 0100001", seg);
                else passed++;
            end
        end
        // Two loads inside one frame: only the later one may ever appear.
        found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (anode == 4'b1110) found = 1;
        end
        value = 16'h5678; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        value = 16'h9ABC; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL two_loads cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (anode == 4'b0111) seen3 = 1;
            if (anode == 4'b1110 && seen3 && !seenc) begin
                seenc = 1; checks++;
                if (seg !== 7'b1000110) $display("FAIL last_load_wins seg=%b expected 1000110", seg);
                else passed++;
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [6];
        logic [3:0]  dps  [6];
        vals[0] = 16'h0050; dps[0] = 4'b0000;
        vals[1] = 16'h0000; dps[1] = 4'b0000;
        vals[2] = 16'h0000; dps[2] = 4'b1000;
        for (int c = 3; c < 6; c++) begin
            vals[c] = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(1, 4)));
            dps[c]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
        end
        lz_blank = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [3:0] vis = '0, exp_vis;
            exp_vis = 4'b0001;
            for (int i = 1; i < DIGITS; i++)
                exp_vis[i] = ((vals[c] >> (4 * i)) != 16'h0) || dps[c][i];
            value = vals[c]; dp_in = dps[c]; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int k = 1; k <= 70; k++) begin
                @(negedge clk);
                checks++;
                if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                    $display("FAIL lz case=%0d cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", c, k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
                else passed++;
                if (k > 38)
                    for (int i = 0; i < DIGITS; i++)
                        if (anode == 4'(~(4'b0001 << i))) vis[i] = 1'b1;
            end
            checks++;
            if (vis !== exp_vis)
                $display("FAIL lz_visible case=%0d value=%h dp=%b shown=%b expected %b", c, vals[c], dps[c], vis, exp_vis);
            else passed++;
        end
        lz_blank = 1'b0; dp_in = 4'b0000;
    endtask

    task automatic test_reset_midscan();
        bit found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clk);
            if (anode == 4'b1011) found = 1;
        end
        checks++;
        if (!found) $display("FAIL wait_digit2 anode=%b expected 1011 within 40 cycles", anode);
        else passed++;
        value = 16'h9999; load = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({anode, seg, dp, fd} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL async_reset anode=%b seg=%b dp=%b fd=%b expected 1111 1111111 1 0", anode, seg, dp, fd);
        else passed++;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL after_reset cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (k == 3) begin
                checks++;
                if (anode !== 4'b1110 || seg !== 7'b1000000)
                    $display("FAIL restart_zero anode=%b seg=%b expected 1110 1000000", anode, seg);
                else passed++;
            end
        end
    endtask

    task automatic test_enable_gap();
        repeat (12) @(negedge clk);
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd || anode !== 4'hF || fd !== 1'b0)
                $display("FAIL en_low cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (k == 2) begin value = 16'h7E15; load = 1'b1; end
            if (k == 3) load = 1'b0;
        end
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL en_rise cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            if (k <= 3) begin
                logic [3:0] ea;
                ea = (k < 3) ? 4'hF : 4'b1110;
                checks++;
                if (anode !== ea || (k == 3 && seg !== 7'b0010010))
                    $display("FAIL restart_slot cyc=%0d anode=%b seg=%b expected %b (seg 0010010 when shown)", k, anode, seg, ea);
                else passed++;
            end
        end
    endtask

    task automatic test_no_blank();
        logic [3:0] prev, cur;
        int run;
        bit found = 0, blank_seen = 0;
        value = 16'h1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (40) @(negedge clk);
        prev = anode2;
        for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk);
            if (anode2 !== prev) found = 1;
            prev = anode2;
        end
        checks++;
        if (!found) $display("FAIL nb_slot_change anode=%b no digit change within 20 cycles", anode2);
        else passed++;
        cur = anode2; run = 1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (anode2 == 4'hF) blank_seen = 1;
            if (anode2 === cur) run++;
            else begin
                checks++;
                if (run != CLK_DIV || anode2 !== {cur[2:0], cur[3]})
                    $display("FAIL nb_slot len=%0d next=%b expected len %0d next %b", run, anode2, CLK_DIV, {cur[2:0], cur[3]});
                else passed++;
                cur = anode2; run = 1;
            end
        end
        checks++;
        if (blank_seen) $display("FAIL nb_gap anode went 1111 expected never with zero blanking");
        else passed++;
    endtask

    task automatic test_random();
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            checks++;
            if (anode !== exp_anode || seg !== exp_seg || dp !== exp_dp || fd !== exp_fd)
                $display("FAIL random cyc=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, anode, seg, dp, fd, exp_anode, exp_seg, exp_dp, exp_fd);
            else passed++;
            en    = ($urandom_range(0, 49) != 0);
            load  = ($urandom_range(0, 11) == 0);
            value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_midframe_load();
        test_lz_blank();
        test_reset_midscan();
        test_enable_gap();
        test_no_blank();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
